// File: rtl/dma_status_register.sv
// dma_status_register: DMA status word (TC latches + request-pending bits) with a snapshot read port
module dma_status_register #(
  parameter int SYNC_STAGES = 2,
  parameter logic [3:0] STATUS_ADDR = 4'h8
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       master_clear,
  input  logic       cs_n,
  input  logic       ior_n,
  input  logic [3:0] addr,
  input  logic [3:0] dreq,
  input  logic       dreq_pol,
  input  logic       ctrl_disable,
  input  logic [3:0] sw_req,
  input  logic [3:0] tc_pulse,
  output logic [7:0] db_out,
  output logic       db_oe,
  output logic       tc_any
);
  typedef enum logic [1:0] {IDLE, READ, RECOVER} state_t;
  state_t state, state_nx;
  logic clr, ior_q, sel, start, done;
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0] req_act, req_sync, tc_flags, tc_nx, snap;
  logic [7:0] status;
  assign clr = RESET | master_clear;
  assign req_act = dreq ~^ {4{dreq_pol}};
  assign req_sync = sync_q[SYNC_STAGES-1];
  assign status = {(req_sync & {4{~ctrl_disable}}) | sw_req, tc_flags};
  assign sel = ~cs_n & (addr == STATUS_ADDR);
  assign start = (state == IDLE) & sel & ~ior_n & ior_q;
  assign done = (state == READ) & (ior_n | cs_n);
  assign tc_nx = (tc_flags & ~(done ? snap : 4'h0)) | tc_pulse;
  // Read FSM state register
  always_ff @(posedge clk)
    state <= clr ? IDLE : state_nx;
  // Read FSM next state: a fresh sampled falling edge is needed to leave IDLE
  always_comb begin
    state_nx = state;
    state_nx = start ? READ : done ? RECOVER : (state == RECOVER && ior_n) ? IDLE : state;
  end
  // DREQ synchronizer after polarity correction
  always_ff @(posedge clk)
    sync_q <= clr ? '0 : {sync_q[SYNC_STAGES-2:0], req_act};
  // Strobe history, TC latches, snapshot and bus outputs; ior_q clears low so a held strobe cannot re-trigger
  always_ff @(posedge clk) begin
    if (clr) begin
      ior_q <= 1'b0;
      tc_flags <= '0;
      tc_any <= 1'b0;
      snap <= '0;
      db_out <= '0;
      db_oe <= 1'b0;
    end else begin
      ior_q <= ior_n;
      tc_flags <= tc_nx;
      tc_any <= |tc_nx;
      snap <= start ? status[3:0] : snap;
      db_out <= start ? status : done ? 8'h00 : db_out;
      db_oe <= start ? 1'b1 : done ? 1'b0 : db_oe;
    end
  end
endmodule
